fx3_packet_reader: RTL and testbench

//  Initiator end of the FPGA->FX3 packet interface; stands in for the FX3 GPIF master in loopback/bring-up builds.

---
 rtl/fx3_packet_reader_if.sv | 30 +++
 rtl/fx3_packet_reader.sv | 126 ++++++++++++
 tb/tb_fx3_packet_reader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx3_packet_reader_if.sv
// Handshake and status bundle between the packet reader and the FX3-side sender.
// The master modport is the reader; the slave modport is the sender and status consumer.
interface fx3_packet_reader_if;
  logic        enable;
  logic        dataAvailable;
  logic        fx3isReading;
  logic [15:0] dataIn;
  logic        checkEnable;
  logic        clearErrors;
  logic        readData;
  logic        wordValid;
  logic [15:0] wordOut;
  logic        packetDone;
  logic [15:0] packetCount;
  logic        lengthError;
  logic        timeoutError;
  logic        seqError;

  modport master (
    input  enable, dataAvailable, fx3isReading, dataIn, checkEnable, clearErrors,
    output readData, wordValid, wordOut, packetDone, packetCount,
           lengthError, timeoutError, seqError
  );

  modport slave (
    output enable, dataAvailable, fx3isReading, dataIn, checkEnable, clearErrors,
    input  readData, wordValid, wordOut, packetDone, packetCount,
           lengthError, timeoutError, seqError
  );
endinterface

// File: rtl/fx3_packet_reader.sv
// Stand-in for the FX3 GPIF master: requests packets, captures words, and checks
// packet length and an optional incrementing pattern with sticky error flags.
module fx3_packet_reader #(
  parameter int PACKET_WORDS  = 8192,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 4
) (
  input logic                  inclk,
  input logic                  nReset,
  fx3_packet_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, GAP} stateT;

  localparam int TIMER_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX) + 1;

  stateT          state;
  stateT          nextState;
  logic [TW-1:0]  timer;
  logic [16:0]    wordCnt;
  logic [15:0]    expected;
  logic           seqValid;
  logic           startTimeout;
  logic           packetEnd;
  logic           wordTaken;
  logic           seqCheck;
  logic           seqMiss;
  logic           lengthBad;

  always_comb begin
    nextState    = state;
    startTimeout = 1'b0;
    packetEnd    = 1'b0;
    wordTaken    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && bus.dataAvailable) nextState = REQUEST;
      end
      REQUEST: begin
        if (bus.fx3isReading) begin
          nextState = RECEIVE;
          wordTaken = 1'b1;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          nextState    = GAP;
          startTimeout = 1'b1;
        end
      end
      RECEIVE: begin
        if (bus.fx3isReading) begin
          wordTaken = 1'b1;
        end else begin
          nextState = GAP;
          packetEnd = 1'b1;
        end
      end
      GAP: begin
        if (timer == TW'(GAP_CYCLES - 1)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Words outside REQUEST/RECEIVE never reach wordTaken, so they are neither counted nor checked.
  assign seqCheck  = wordTaken && bus.checkEnable;
  assign seqMiss   = seqCheck && seqValid && (bus.dataIn != expected);
  assign lengthBad = packetEnd && (wordCnt != 17'(PACKET_WORDS));

  // readData follows the next state so it is a clean register output matching REQUEST/RECEIVE.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      timer        <= '0;
      bus.readData <= 1'b0;
    end else begin
      state        <= nextState;
      timer        <= (nextState != state) ? '0 : timer + TW'(1);
      bus.readData <= (nextState == REQUEST) || (nextState == RECEIVE);
    end
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      wordCnt         <= '0;
      bus.packetDone  <= 1'b0;
      bus.packetCount <= '0;
      bus.wordOut     <= '0;
      bus.wordValid   <= 1'b0;
    end else begin
      bus.wordOut    <= bus.dataIn;
      bus.wordValid  <= bus.fx3isReading;
      bus.packetDone <= packetEnd;
      if (packetEnd) bus.packetCount <= bus.packetCount + 16'd1;
      if (wordTaken && (state == REQUEST)) begin
        wordCnt <= 17'd1;
      end else if (wordTaken && (wordCnt != 17'h1FFFF)) begin
        wordCnt <= wordCnt + 17'd1;
      end
    end
  end

  // A fresh error event outranks a simultaneous clearErrors pulse.
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      bus.lengthError  <= 1'b0;
      bus.timeoutError <= 1'b0;
      bus.seqError     <= 1'b0;
      seqValid         <= 1'b0;
      expected         <= '0;
    end else begin
      if (lengthBad)             bus.lengthError <= 1'b1;
      else if (bus.clearErrors)  bus.lengthError <= 1'b0;
      if (startTimeout)          bus.timeoutError <= 1'b1;
      else if (bus.clearErrors)  bus.timeoutError <= 1'b0;
      if (seqMiss)               bus.seqError <= 1'b1;
      else if (bus.clearErrors)  bus.seqError <= 1'b0;
      if (seqCheck) begin
        seqValid <= 1'b1;
        expected <= bus.dataIn + 16'd1;
      end else if (bus.clearErrors) begin
        seqValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fx3_packet_reader.sv
// Directed bench for fx3_packet_reader: a small sender model serves packets and each
// scenario task compares outputs against hand-derived values.
module tb_fx3_packet_reader;

  localparam int GAP_CYCLES = 4;

  logic clk;
  logic nReset;
  int   errors = 0;
  int   checks = 0;

  fx3_packet_reader_if bus();

  fx3_packet_reader dut (
    .inclk  (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns at the first negedge with readData high; lowCnt counts the low samples before it.
  task automatic waitRequest(output int lowCnt, output bit got);
    lowCnt = 0;
    got    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.readData) begin
        got = 1'b1;
        break;
      end
      lowCnt++;
    end
  endtask

  task automatic sendWords(input int n, input logic [15:0] base, input int dropAt,
                           output logic [15:0] firstOut, output logic firstValid);
    firstOut   = 16'h0;
    firstValid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == dropAt) bus.enable = 1'b0;
      bus.fx3isReading = 1'b1;
      bus.dataIn       = base + 16'(i);
      @(negedge clk);
      if (i == 0) begin
        firstOut   = bus.wordOut;
        firstValid = bus.wordValid;
      end
    end
    bus.fx3isReading = 1'b0;
    bus.dataIn       = 16'h0;
  endtask

  task automatic endPacket(output logic doneNow, output logic doneAfter);
    @(negedge clk);
    doneNow = bus.packetDone;
    @(negedge clk);
    doneAfter = bus.packetDone;
  endtask

  task automatic pulseClear();
    bus.clearErrors = 1'b1;
    @(negedge clk);
    bus.clearErrors = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    int          reqSeen;
    nReset           = 1'b0;
    bus.enable       = 1'b1;
    bus.dataAvailable= 1'b1;
    bus.fx3isReading = 1'b1;
    bus.dataIn       = 16'h5555;
    bus.checkEnable  = 1'b0;
    bus.clearErrors  = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.readData, bus.wordValid, bus.wordOut, bus.packetDone, bus.packetCount,
            bus.lengthError, bus.timeoutError, bus.seqError};
    checks++;
    if (outs !== 38'h0) begin
      errors++;
      $display("[TB] FAIL resetOutputs: got %0h, expected 0", outs);
    end
    bus.dataAvailable = 1'b0;
    bus.fx3isReading  = 1'b0;
    bus.dataIn        = 16'h0;
    nReset            = 1'b1;
    reqSeen           = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.readData) reqSeen++;
    end
    checks++;
    if (reqSeen !== 0) begin
      errors++;
      $display("[TB] FAIL noDataNoRequest: got %0d request cycles, expected 0", reqSeen);
    end
    bus.dataAvailable = 1'b1;
    bus.checkEnable   = 1'b1;
  endtask

  task automatic test_full_packet();
    int lowCnt; bit got; logic [15:0] fo; logic fv, dn, da;
    waitRequest(lowCnt, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("[TB] FAIL firstRequest: got %0d, expected 1", got); end
    sendWords(8192, 16'h0000, -1, fo, fv);
    checks++;
    if ({fv, fo} !== 17'h10000) begin
      errors++; $display("[TB] FAIL captureFirstWord: got %0h, expected 10000", {fv, fo});
    end
    endPacket(dn, da);
    checks++;
    if ({dn, da} !== 2'b10) begin errors++; $display("[TB] FAIL donePulse: got %b, expected 10", {dn, da}); end
    checks++;
    if (bus.packetCount !== 16'd1) begin
      errors++; $display("[TB] FAIL countAfterFull: got %0d, expected 1", bus.packetCount);
    end
    checks++;
    if ({bus.lengthError, bus.timeoutError, bus.seqError} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL fullPacketFlags: got %b, expected 000",
               {bus.lengthError, bus.timeoutError, bus.seqError});
    end
    // Low time is the GAP cycles plus the single IDLE cycle before the next request.
    waitRequest(lowCnt, got);
    checks++;
    if (!got || (lowCnt + 2) < GAP_CYCLES || (lowCnt + 2) > GAP_CYCLES + 1) begin
      errors++; $display("[TB] FAIL gapAfterPacket: got %0d low cycles (got=%0d), expected 4..5", lowCnt + 2, got);
    end
  endtask

  task automatic test_length();
    int lowCnt; bit got; logic [15:0] fo; logic fv, dn, da;
    sendWords(8191, 16'd8192, -1, fo, fv);
    endPacket(dn, da);
    checks++;
    if ({dn, bus.packetCount, bus.lengthError, bus.seqError} !== {1'b1, 16'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL shortPacket: got done=%0d cnt=%0d len=%0d seq=%0d, expected 1 2 1 0",
               dn, bus.packetCount, bus.lengthError, bus.seqError);
    end
    pulseClear();
    checks++;
    if (bus.lengthError !== 1'b0) begin errors++; $display("[TB] FAIL clearShort: got %0d, expected 0", bus.lengthError); end
    waitRequest(lowCnt, got);
    sendWords(8193, 16'd16383, -1, fo, fv);
    endPacket(dn, da);
    checks++;
    if ({dn, bus.packetCount, bus.lengthError, bus.seqError} !== {1'b1, 16'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL longPacket: got done=%0d cnt=%0d len=%0d seq=%0d, expected 1 3 1 0",
               dn, bus.packetCount, bus.lengthError, bus.seqError);
    end
    pulseClear();
    checks++;
    if (bus.lengthError !== 1'b0) begin errors++; $display("[TB] FAIL clearLong: got %0d, expected 0", bus.lengthError); end
    waitRequest(lowCnt, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("[TB] FAIL requestBeforeTimeout: got %0d, expected 1", got); end
  endtask

  task automatic test_timeout();
    int reqCycles; int lowCnt; bit got;
    checks++;
    if (bus.timeoutError !== 1'b0) begin errors++; $display("[TB] FAIL timeoutEarly: got %0d, expected 0", bus.timeoutError); end
    reqCycles = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.readData) break;
      reqCycles++;
    end
    checks++;
    if (reqCycles !== 64) begin errors++; $display("[TB] FAIL timeoutCycles: got %0d, expected 64", reqCycles); end
    checks++;
    if ({bus.timeoutError, bus.lengthError, bus.packetCount} !== {1'b1, 1'b0, 16'd3}) begin
      errors++;
      $display("[TB] FAIL timeoutFlags: got to=%0d len=%0d cnt=%0d, expected 1 0 3",
               bus.timeoutError, bus.lengthError, bus.packetCount);
    end
    waitRequest(lowCnt, got);
    checks++;
    if (!got || (lowCnt + 1) < GAP_CYCLES || (lowCnt + 1) > GAP_CYCLES + 1) begin
      errors++; $display("[TB] FAIL timeoutGap: got %0d low cycles (got=%0d), expected 4..5", lowCnt + 1, got);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] pat [4];
    logic        expSeq [4];
    int lowCnt; bit got; logic [15:0] fo; logic fv, dn, da;
    pat    = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0002};
    expSeq = '{1'b0, 1'b0, 1'b0, 1'b1};
    pulseClear();
    checks++;
    if (bus.timeoutError !== 1'b0) begin errors++; $display("[TB] FAIL clearTimeout: got %0d, expected 0", bus.timeoutError); end
    for (int i = 0; i < 4; i++) begin
      bus.fx3isReading = 1'b1;
      bus.dataIn       = pat[i];
      @(negedge clk);
      checks++;
      if (bus.seqError !== expSeq[i]) begin
        errors++; $display("[TB] FAIL seqWord%0d: got %0d, expected %0d", i, bus.seqError, expSeq[i]);
      end
    end
    bus.fx3isReading = 1'b0;
    bus.dataIn       = 16'h0;
    endPacket(dn, da);
    checks++;
    if ({dn, bus.packetCount, bus.lengthError} !== {1'b1, 16'd4, 1'b1}) begin
      errors++; $display("[TB] FAIL patternPacket: got done=%0d cnt=%0d len=%0d, expected 1 4 1",
                         dn, bus.packetCount, bus.lengthError);
    end
    pulseClear();
    checks++;
    if ({bus.seqError, bus.lengthError} !== 2'b00) begin
      errors++; $display("[TB] FAIL clearSeq: got %b, expected 00", {bus.seqError, bus.lengthError});
    end
    waitRequest(lowCnt, got);
    sendWords(8192, 16'h1234, -1, fo, fv);
    endPacket(dn, da);
    checks++;
    if ({dn, bus.packetCount, bus.lengthError, bus.seqError} !== {1'b1, 16'd5, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL reseedPacket: got done=%0d cnt=%0d len=%0d seq=%0d, expected 1 5 0 0",
                         dn, bus.packetCount, bus.lengthError, bus.seqError);
    end
    waitRequest(lowCnt, got);
  endtask

  task automatic test_reset_midpacket();
    int lowCnt; bit got; logic [15:0] fo; logic fv, dn, da;
    sendWords(4000, 16'h0000, -1, fo, fv);
    checks++;
    if (bus.readData !== 1'b1) begin errors++; $display("[TB] FAIL readBeforeReset: got %0d, expected 1", bus.readData); end
    nReset = 1'b0;
    #1;
    checks++;
    if ({bus.readData, bus.packetCount, bus.wordValid, bus.wordOut} !== 34'h0) begin
      errors++; $display("[TB] FAIL asyncReset: got rd=%0d cnt=%0d valid=%0d word=%0h, expected all 0",
                         bus.readData, bus.packetCount, bus.wordValid, bus.wordOut);
    end
    @(negedge clk);
    nReset = 1'b1;
    waitRequest(lowCnt, got);
    sendWords(8192, 16'h0000, -1, fo, fv);
    endPacket(dn, da);
    checks++;
    if ({dn, bus.packetCount, bus.lengthError, bus.timeoutError, bus.seqError} !== {1'b1, 16'd1, 3'b000}) begin
      errors++; $display("[TB] FAIL afterReset: got done=%0d cnt=%0d flags=%b, expected 1 1 000",
                         dn, bus.packetCount, {bus.lengthError, bus.timeoutError, bus.seqError});
    end
  endtask

  task automatic test_enable_drop();
    int lowCnt; int reqSeen; bit got; logic [15:0] fo; logic fv, dn, da;
    waitRequest(lowCnt, got);
    sendWords(8192, 16'd8192, 100, fo, fv);
    endPacket(dn, da);
    checks++;
    if ({dn, bus.packetCount, bus.lengthError, bus.seqError} !== {1'b1, 16'd2, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL enableDropPacket: got done=%0d cnt=%0d len=%0d seq=%0d, expected 1 2 0 0",
                         dn, bus.packetCount, bus.lengthError, bus.seqError);
    end
    // A stray word while idle must show on wordOut but stay out of the counters and checker.
    reqSeen = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) begin
        bus.fx3isReading = 1'b1;
        bus.dataIn       = 16'hABCD;
      end else begin
        bus.fx3isReading = 1'b0;
        bus.dataIn       = 16'h0;
      end
      @(negedge clk);
      if (bus.readData) reqSeen++;
      if (i == 20) begin
        checks++;
        if ({bus.wordValid, bus.wordOut} !== 17'h1ABCD) begin
          errors++; $display("[TB] FAIL idleCapture: got %0h, expected 1abcd", {bus.wordValid, bus.wordOut});
        end
      end
    end
    checks++;
    if (reqSeen !== 0) begin errors++; $display("[TB] FAIL noRequestDisabled: got %0d, expected 0", reqSeen); end
    checks++;
    if ({bus.packetCount, bus.seqError, bus.lengthError} !== {16'd2, 2'b00}) begin
      errors++; $display("[TB] FAIL idleWordIgnored: got cnt=%0d seq=%0d len=%0d, expected 2 0 0",
                         bus.packetCount, bus.seqError, bus.lengthError);
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_length();
    test_timeout();
    test_sequence();
    test_reset_midpacket();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
